// File: rtl/mux_nx1_rr_reg_pkg.sv
// Shared constants and helpers for the N:1 registered selector.
// Defines the mode encodings, the default sizes and the round-robin pointer increment.
package mux_pkg;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 4;

  // Wraps at n rather than at a power of two, so non-power-of-two NUM_IN works.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_nx1_rr_reg_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// The search starts at ptr, moves upward and wraps from NUM_IN-1 back to 0.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic [SEL_W:0]   pos;
  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      // One extra bit holds ptr+k before it is folded back into range.
      pos = {1'b0, ptr} + (SEL_W+1)'(k);
      if (pos >= NUM_IN_W) pos = pos - NUM_IN_W;
      idx = pos[SEL_W-1:0];
      if (!gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr_reg.sv
// N:1 selector with a registered output stage, valid/ready on every port,
// and either explicit (sel) or round-robin source choice.
module mux_nx1_rr_reg
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    sel_err
);

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_IN-1:0] rr_gnt;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;

  logic [NUM_IN-1:0] exp_gnt;
  logic              sel_oor;
  logic [NUM_IN-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              load_en;
  logic              take;
  logic [WIDTH-1:0]  gnt_data;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  assign sel_oor = ({1'b0, sel} >= NUM_IN_W);

  // An out-of-range sel matches no index, so it yields no grant by construction.
  always_comb begin
    exp_gnt = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      exp_gnt[i] = (sel == SEL_W'(i)) && in_valid[i];
    end
  end

  always_comb begin
    if (mode == MODE_RR) begin
      gnt     = rr_gnt;
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end else begin
      gnt     = exp_gnt;
      gnt_idx = sel;
      gnt_any = |exp_gnt;
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt[i]) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Handshake: a word moves across a port in any cycle where valid and ready
  // are both high. in_ready depends only on the grant (never on data) and on
  // whether the output register is free or being drained this cycle; the
  // producer must hold its word until it sees ready.
  assign load_en  = !out_valid || out_ready;
  assign in_ready = gnt & {NUM_IN{load_en}};
  assign take     = load_en && gnt_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      sel_err   <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      sel_err <= (mode == MODE_EXPLICIT) && sel_oor;
      if (take) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_src   <= gnt_idx;
        if (mode == MODE_RR) begin
          rr_ptr <= SEL_W'(rr_next(int'(gnt_idx), NUM_IN));
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr_reg.sv
// Directed bench for mux_nx1_rr_reg: a 4-input instance driven from a vector
// table and hand-written sequences, plus a 3-input instance for wrap and sel errors.
module tb_mux_nx1_rr_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         mode4, ordy4, ov4, err4;
  logic [1:0]   sel4, os4;
  logic [3:0]   vld4, rdy4;
  logic [127:0] data4;
  logic [31:0]  od4;

  logic         mode3, ordy3, ov3, err3;
  logic [1:0]   sel3, os3;
  logic [2:0]   vld3, rdy3;
  logic [95:0]  data3;
  logic [31:0]  od3;

  mux_nx1_rr_reg #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4),
    .in_valid(vld4), .in_data(data4), .in_ready(rdy4),
    .out_valid(ov4), .out_ready(ordy4), .out_data(od4),
    .out_src(os4), .sel_err(err4)
  );

  mux_nx1_rr_reg #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_valid(vld3), .in_data(data3), .in_ready(rdy3),
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3),
    .out_src(os3), .sel_err(err3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Inputs are already driven; check in_ready, clock once, check the register.
  task automatic step4(input string nm, input logic [3:0] erdy, input logic eov,
                       input logic [1:0] esrc, input logic [31:0] edata);
    #1;
    chk({nm, " in_ready"}, 32'(rdy4), 32'(erdy));
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, 32'(ov4), 32'(eov));
    chk({nm, " out_src"}, 32'(os4), 32'(esrc));
    chk({nm, " out_data"}, od4, edata);
    chk({nm, " sel_err"}, 32'(err4), 32'd0);
  endtask

  task automatic step3(input string nm, input logic [2:0] erdy, input logic eov,
                       input logic [1:0] esrc, input logic [31:0] edata, input logic eerr);
    #1;
    chk({nm, " in_ready"}, 32'(rdy3), 32'(erdy));
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, 32'(ov3), 32'(eov));
    chk({nm, " out_src"}, 32'(os3), 32'(esrc));
    chk({nm, " out_data"}, od3, edata);
    chk({nm, " sel_err"}, 32'(err3), 32'(eerr));
  endtask

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  src;
    logic [31:0] data;
  } vec_t;

  vec_t vt[8];

  initial begin
    // Explicit-mode table; each row is one cycle and carries state from the row before.
    vt[0] = '{1'b0, 2'd2, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 32'hA5A5_0002};
    vt[1] = '{1'b0, 2'd2, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hA5A5_0002};
    vt[2] = '{1'b0, 2'd2, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hA5A5_0002};
    vt[3] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA5A5_0002};
    vt[4] = '{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA5A5_0001};
    vt[5] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd1, 32'hA5A5_0001};
    vt[6] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 32'hA5A5_0000};
    vt[7] = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'hA5A5_0000};

    // Reset with random inputs.
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mode4 = 1'($urandom_range(0, 1)); sel4 = 2'($urandom_range(0, 3));
      vld4  = 4'($urandom_range(0, 15)); ordy4 = 1'($urandom_range(0, 1));
      data4 = {$urandom, $urandom, $urandom, $urandom};
      mode3 = 1'($urandom_range(0, 1)); sel3 = 2'($urandom_range(0, 3));
      vld3  = 3'($urandom_range(0, 7)); ordy3 = 1'($urandom_range(0, 1));
      data3 = {$urandom, $urandom, $urandom};
      @(posedge clk);
    end
    #1;
    chk("rst out_valid4", 32'(ov4), 32'd0);
    chk("rst out_data4", od4, 32'd0);
    chk("rst out_src4", 32'(os4), 32'd0);
    chk("rst sel_err4", 32'(err4), 32'd0);
    chk("rst out_valid3", 32'(ov3), 32'd0);
    chk("rst out_data3", od3, 32'd0);
    chk("rst out_src3", 32'(os3), 32'd0);
    chk("rst sel_err3", 32'(err3), 32'd0);

    mode4 = 1'b0; sel4 = 2'd0; vld4 = 4'b0; ordy4 = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; vld3 = 3'b0; ordy3 = 1'b1;
    data4 = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    data3 = {32'h32, 32'h31, 32'h30};
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      mode4 = vt[i].mode; sel4 = vt[i].sel; vld4 = vt[i].vld; ordy4 = vt[i].ordy;
      step4($sformatf("xv%0d", i), vt[i].rdy, vt[i].ov, vt[i].src, vt[i].data);
    end

    // Round-robin, all valid, consumer always ready: 0,1,2,3,0,... back to back.
    data4 = {32'd3, 32'd2, 32'd1, 32'd0};
    mode4 = 1'b1; vld4 = 4'b1111; ordy4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step4($sformatf("rr%0d", k), 4'(1 << (k % 4)), 1'b1, 2'(k % 4), 32'(k % 4));
    end

    // Skip idle inputs: pointer at 0, only 1 and 3 requesting.
    vld4 = 4'b1010;
    step4("skip0", 4'b0010, 1'b1, 2'd1, 32'd1);
    step4("skip1", 4'b1000, 1'b1, 2'd3, 32'd3);
    step4("skip2", 4'b0010, 1'b1, 2'd1, 32'd1);
    step4("skip3", 4'b1000, 1'b1, 2'd3, 32'd3);
    vld4 = 4'b0001;
    step4("skip4", 4'b0001, 1'b1, 2'd0, 32'd0);

    // Bring pointer to 2, do explicit transfers, then resume round-robin at 2.
    vld4 = 4'b1111;
    step4("ms_rr", 4'b0010, 1'b1, 2'd1, 32'd1);
    mode4 = 1'b0; sel4 = 2'd0;
    step4("ms_x0", 4'b0001, 1'b1, 2'd0, 32'd0);
    step4("ms_x1", 4'b0001, 1'b1, 2'd0, 32'd0);
    step4("ms_x2", 4'b0001, 1'b1, 2'd0, 32'd0);
    mode4 = 1'b1;
    step4("ms_back", 4'b0100, 1'b1, 2'd2, 32'd2);

    // Consumer stall in round-robin: output held, no input ready.
    ordy4 = 1'b0;
    step4("stall0", 4'b0000, 1'b1, 2'd2, 32'd2);
    step4("stall1", 4'b0000, 1'b1, 2'd2, 32'd2);
    ordy4 = 1'b1;
    step4("unstall", 4'b1000, 1'b1, 2'd3, 32'd3);
    step4("rr_wrap", 4'b0001, 1'b1, 2'd0, 32'd0);
    ordy4 = 1'b0;
    step4("hold", 4'b0000, 1'b1, 2'd0, 32'd0);

    // Asynchronous reset mid-operation, away from any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(ov4), 32'd0);
    chk("async out_data", od4, 32'd0);
    chk("async out_src", 32'(os4), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ordy4 = 1'b1;
    step4("post_rst", 4'b0001, 1'b1, 2'd0, 32'd0);
    vld4 = 4'b0000;
    step4("drain", 4'b0000, 1'b0, 2'd0, 32'd0);

    // Three-input build: pointer wraps 2 -> 0.
    mode3 = 1'b1; vld3 = 3'b111; ordy3 = 1'b1;
    step3("n3rr0", 3'b001, 1'b1, 2'd0, 32'h30, 1'b0);
    step3("n3rr1", 3'b010, 1'b1, 2'd1, 32'h31, 1'b0);
    step3("n3rr2", 3'b100, 1'b1, 2'd2, 32'h32, 1'b0);
    step3("n3rr3", 3'b001, 1'b1, 2'd0, 32'h30, 1'b0);

    // Out-of-range sel: no grant, sel_err every following cycle.
    mode3 = 1'b0; sel3 = 2'd3;
    step3("serr0", 3'b000, 1'b0, 2'd0, 32'h30, 1'b1);
    step3("serr1", 3'b000, 1'b0, 2'd0, 32'h30, 1'b1);
    step3("serr2", 3'b000, 1'b0, 2'd0, 32'h30, 1'b1);
    sel3 = 2'd1;
    step3("serr_end", 3'b010, 1'b1, 2'd1, 32'h31, 1'b0);
    sel3 = 2'd2; vld3 = 3'b011;
    step3("x3_noval", 3'b000, 1'b0, 2'd1, 32'h31, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr_reg.md
Name: mux_nx1_rr_reg

Overview:
- Parametrised successor of the 4:1 combinational multiplexor.
- N-input, one-output selector with a registered output stage and valid/ready handshake on every input and on the output.
- Two modes:
  - explicit select, where the sel port picks the source;
  - round-robin, where the block arbitrates among valid inputs.
- Sits between multi-cycle datapath producers (register file, ALU result, memory data, PC sources) and a single consumer that may stall.

Parameters:
- WIDTH, 32, data width per input.
- NUM_IN, 4, number of inputs; legal range 2..16.
- SEL_W, derived localparam ($clog2(NUM_IN)), not overridable; width of sel and out_src.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = explicit select via sel, 1 = round-robin arbitration.
- sel  input  SEL_W  source index in explicit mode; ignored in round-robin mode.
- in_valid  input  NUM_IN  per-input valid; bit i belongs to input i.
- in_data  input  NUM_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_IN  per-input ready; combinational; at most one bit high.
- out_valid  output  1  output register holds an unconsumed word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SEL_W  registered index of the input that produced out_data.
- sel_err  output  1  registered one-cycle pulse; explicit mode, sel >= NUM_IN, and in_valid of no legal input accepted that cycle.

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, out_src=0, sel_err=0, round-robin pointer rr_ptr=0.
- Load condition: load_en = !out_valid || out_ready.
  - Output register takes a new word only when load_en is high and a grant exists.
  - Otherwise out_data and out_src hold, and out_valid clears when out_ready is high.
- Grant, explicit mode:
  - grant = onehot(sel) if sel < NUM_IN and in_valid[sel] = 1; else no grant.
  - Other valid inputs are never granted.
- Grant, round-robin mode:
  - Search in_valid starting at index rr_ptr, ascending with wrap at NUM_IN-1 -> 0.
  - The first valid input wins.
- Handshake: in_ready[i] = grant[i] && load_en.
  - A transfer on input i occurs when in_valid[i] && in_ready[i].
  - in_ready never depends on in_data.
- Latency: one cycle. Word accepted in cycle t appears on out_data with out_valid=1 in cycle t+1.
- Throughput: one word per cycle when out_ready is held high.
- Simultaneous events: when out_ready=1 in the same cycle as a new accept, out_valid stays 1 and data is replaced. No bubble, no loss.
- Pointer update: rr_ptr <= (granted_index+1) mod NUM_IN.
  - Updates only on an accepted transfer in round-robin mode.
  - Explicit-mode transfers leave rr_ptr unchanged.
- Mode change: takes effect on the same cycle's grant computation. A word already in the output register is unaffected.
- Wrap-around: with NUM_IN not a power of two, pointer increment wraps at NUM_IN, never at 2^SEL_W.
- sel out of range: no grant and no transfer; sel_err pulses the next cycle, for every cycle the condition holds.
- Reset mid-operation: the pending output word is discarded, out_valid drops immediately (asynchronous), and the pointer returns to 0.
- Stability: while out_valid=1 and out_ready=0, out_data and out_src are held constant.

Decomposition:
- Shared package mux_pkg:
  - MODE_EXPLICIT = 1'b0, MODE_RR = 1'b1;
  - default WIDTH / NUM_IN constants;
  - function for the next round-robin index (increment with wrap at NUM_IN).
- Sub-module rr_arbiter:
  - inputs: req[NUM_IN], ptr[SEL_W];
  - outputs: gnt[NUM_IN] one-hot, gnt_idx[SEL_W], gnt_any;
  - purely combinational rotating priority.
- The top holds the output register, the pointer register and the handshake logic.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_data=0, out_src=0, sel_err=0. Assert rst_n while out_valid=1 -> out_valid drops without a clock edge.
- Explicit mode stall: mode=0, sel=2, in_data[2]=0xA5A5_0002, all in_valid=1, out_ready=0 ->
  - one cycle later out_data=0xA5A5_0002, out_src=2;
  - in_ready=0 until out_ready=1;
  - in_ready[0,1,3] never high.
- Round-robin order: mode=1, all valid, out_ready=1, in_data[i]=i -> out_src sequence 0,1,2,3,0,…, one word per cycle, no bubbles.
- Round-robin skip and pointer: in_valid=4'b1010, rr_ptr=0 -> grants 1,3,1,3. Then in_valid=4'b0001 -> grant 0 next cycle. NUM_IN=3 build: pointer wraps 2->0.
- Mode switch: run round-robin to rr_ptr=2, switch to mode=0, sel=0 for 3 transfers, return to mode=1 -> first round-robin grant is input 2.
- sel error: NUM_IN=3, mode=0, sel=3, in_valid=3'b111 -> no in_ready, out_valid stays 0, sel_err=1 each cycle after.
